// File: rtl/rst_seq_gen.sv
// Reset sequencer: synchronises and debounces reset/lock sources, then
// releases NUM_CH reset domains in order and records the reset cause.
module rst_seq_gen #(
  parameter int NUM_CH       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int STAGE_GAP    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_rst_n,
  input  logic              aux_rst_n,
  input  logic              dbg_rst,
  input  logic              pll_locked,
  input  logic              sw_rst_req,
  input  logic              cause_clr,
  output logic [NUM_CH-1:0] rst_out_n,
  output logic [NUM_CH-1:0] rst_out,
  output logic              seq_done,
  output logic [5:0]        rst_cause
);

  localparam int CMAX = (DEBOUNCE_CYC > STAGE_GAP) ?
                        DEBOUNCE_CYC : STAGE_GAP;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int IW   = $clog2(NUM_CH) + 1;

  typedef enum logic [1:0] {
    S_HOLD,
    S_DEBOUNCE,
    S_RELEASE,
    S_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] r_ext_sync;
  logic [SYNC_STAGES-1:0] r_aux_sync;
  logic [SYNC_STAGES-1:0] r_dbg_sync;
  logic [SYNC_STAGES-1:0] r_lock_sync;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_idx_nxt;
  logic [NUM_CH-1:0] r_out_n;
  logic [NUM_CH-1:0] w_out_n_nxt;
  logic [NUM_CH-1:0] w_idx_mask;
  logic              r_done;
  logic              w_done_nxt;
  logic [5:0]        r_cause;
  logic [5:0]        w_cause_nxt;

  logic       w_ext_s;
  logic       w_aux_s;
  logic       w_dbg_s;
  logic       w_lock_s;
  logic       w_any;
  logic       w_latch;
  logic [5:0] w_new_cause;

  // Synchroniser flops power up holding the asserted level of each source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_sync  <= '0;
      r_aux_sync  <= '0;
      r_dbg_sync  <= '1;
      r_lock_sync <= '0;
    end else begin
      r_ext_sync  <= {r_ext_sync[SYNC_STAGES-2:0], ext_rst_n};
      r_aux_sync  <= {r_aux_sync[SYNC_STAGES-2:0], aux_rst_n};
      r_dbg_sync  <= {r_dbg_sync[SYNC_STAGES-2:0], dbg_rst};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign w_ext_s  = r_ext_sync[SYNC_STAGES-1];
  assign w_aux_s  = r_aux_sync[SYNC_STAGES-1];
  assign w_dbg_s  = r_dbg_sync[SYNC_STAGES-1];
  assign w_lock_s = r_lock_sync[SYNC_STAGES-1];

  assign w_any = ~w_ext_s | ~w_aux_s | w_dbg_s |
                 ~w_lock_s | sw_rst_req;

  assign w_latch = w_any &
                   ((r_state == S_RELEASE) | (r_state == S_RUN));

  assign w_new_cause = {sw_rst_req, ~w_lock_s, w_dbg_s,
                        ~w_aux_s, ~w_ext_s, 1'b0};

  always_comb begin
    w_idx_mask = '0;
    for (int k = 0; k < NUM_CH; k++)
      w_idx_mask[k] = (r_idx == IW'(k));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_out_n <= '0;
      r_done  <= 1'b0;
      r_cause <= 6'b000001;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_out_n <= w_out_n_nxt;
      r_done  <= w_done_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_out_n_nxt = r_out_n;
    w_done_nxt  = r_done;
    // A clear coinciding with a latch leaves exactly the new bits
    w_cause_nxt = (cause_clr ? 6'b0 : r_cause) |
                  (w_latch ? w_new_cause : 6'b0);

    unique case (r_state)
      S_HOLD: begin
        w_out_n_nxt = '0;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        if (!w_any)
          w_state_nxt = S_DEBOUNCE;
      end
      S_DEBOUNCE: begin
        if (w_any) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
          w_cnt_nxt      = '0;
          w_idx_nxt      = IW'(1);
          w_out_n_nxt    = '0;
          w_out_n_nxt[0] = 1'b1;
          if (NUM_CH == 1) begin
            w_state_nxt = S_RUN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_RELEASE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RELEASE: begin
        if (w_any) begin
          w_state_nxt = S_HOLD;
          w_out_n_nxt = '0;
          w_done_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(STAGE_GAP - 1)) begin
          w_cnt_nxt   = '0;
          w_out_n_nxt = r_out_n | w_idx_mask;
          w_idx_nxt   = r_idx + IW'(1);
          if (r_idx == IW'(NUM_CH - 1)) begin
            w_state_nxt = S_RUN;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (w_any) begin
          w_state_nxt = S_HOLD;
          w_out_n_nxt = '0;
          w_done_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_HOLD;
        w_out_n_nxt = '0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  assign rst_out_n = r_out_n;
  assign rst_out   = ~r_out_n;
  assign seq_done  = r_done;
  assign rst_cause = r_cause;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: directed vector table plus randomized run
// against a quiet-time based reference model.
module tb_rst_seq_gen;

  localparam int NCH = 4;
  localparam int SS  = 2;
  localparam int DEB = 16;
  localparam int GAP = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ext_rst_n;
  logic           aux_rst_n;
  logic           dbg_rst;
  logic           pll_locked;
  logic           sw_rst_req;
  logic           cause_clr;
  logic [NCH-1:0] rst_out_n;
  logic [NCH-1:0] rst_out;
  logic           seq_done;
  logic [5:0]     rst_cause;

  int checks   = 0;
  int failures = 0;

  rst_seq_gen #(
    .NUM_CH      (NCH),
    .SYNC_STAGES (SS),
    .DEBOUNCE_CYC(DEB),
    .STAGE_GAP   (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ext_rst_n (ext_rst_n),
    .aux_rst_n (aux_rst_n),
    .dbg_rst   (dbg_rst),
    .pll_locked(pll_locked),
    .sw_rst_req(sw_rst_req),
    .cause_clr (cause_clr),
    .rst_out_n (rst_out_n),
    .rst_out   (rst_out),
    .seq_done  (seq_done),
    .rst_cause (rst_cause)
  );

  always #31 clk = ~clk;

  // Reference model: a domain is released once enough consecutive
  // source-free edges have been seen; sources arrive via a delay line.
  int   m_quiet;
  logic [5:0] m_cause;
  logic q_ext[$];
  logic q_aux[$];
  logic q_dbg[$];
  logic q_lock[$];

  task automatic model_reset();
    m_quiet = 0;
    m_cause = 6'b000001;
    q_ext.delete();
    q_aux.delete();
    q_dbg.delete();
    q_lock.delete();
    for (int i = 0; i < SS; i++) begin
      q_ext.push_back(1'b0);
      q_aux.push_back(1'b0);
      q_dbg.push_back(1'b1);
      q_lock.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    logic es, as, ds, ls, any, was_rel;
    logic [5:0] nb;
    es = q_ext.pop_front();
    as = q_aux.pop_front();
    ds = q_dbg.pop_front();
    ls = q_lock.pop_front();
    q_ext.push_back(ext_rst_n);
    q_aux.push_back(aux_rst_n);
    q_dbg.push_back(dbg_rst);
    q_lock.push_back(pll_locked);
    any = !es || !as || ds || !ls || sw_rst_req;
    was_rel = (m_quiet >= 1 + DEB);
    nb = {sw_rst_req, !ls, ds, !as, !es, 1'b0};
    if (any && was_rel)
      m_cause = cause_clr ? nb : (m_cause | nb);
    else if (cause_clr)
      m_cause = 6'b0;
    if (any)
      m_quiet = 0;
    else if (m_quiet < 100000)
      m_quiet = m_quiet + 1;
  endtask

  function automatic logic [NCH-1:0] model_out_n();
    logic [NCH-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++)
      r[k] = (m_quiet >= 1 + DEB + k * GAP);
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [NCH-1:0] eon,
                     input logic ed,
                     input logic [5:0] ec);
    checks++;
    if (rst_out_n !== eon || rst_out !== ~eon ||
        seq_done !== ed || rst_cause !== ec) begin
      failures++;
      $display("FAIL %s t=%0t: got out_n=%b out=%b done=%b cause=%b want out_n=%b done=%b cause=%b",
               nm, $time, rst_out_n, rst_out, seq_done, rst_cause,
               eon, ed, ec);
    end
  endtask

  task automatic model_check();
    logic [NCH-1:0] eo;
    eo = model_out_n();
    chk("model", eo, &eo, m_cause);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic async_por();
    #5 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_por", 4'b0000, 1'b0, 6'b000001);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic       e, a, d, l, s, c;
    int         n;
    logic [3:0] on;
    logic       dn;
    logic [5:0] ca;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic e, logic a, logic d, logic l,
                              logic s, logic c, int n,
                              logic [3:0] on, logic dn,
                              logic [5:0] ca);
    vec_t v;
    v.e = e; v.a = a; v.d = d; v.l = l; v.s = s; v.c = c;
    v.n = n; v.on = on; v.dn = dn; v.ca = ca;
    return v;
  endfunction

  int h_ext, h_aux, h_dbg, h_lock;

  initial begin
    rst_n      = 1'b0;
    ext_rst_n  = 1'b1;
    aux_rst_n  = 1'b1;
    dbg_rst    = 1'b0;
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;
    cause_clr  = 1'b0;
    model_reset();

    tbl.push_back(mk(1,1,0,1,0,0,18,4'b0000,0,6'b000001));
    tbl.push_back(mk(1,1,0,1,0,0, 1,4'b0001,0,6'b000001));
    tbl.push_back(mk(1,1,0,1,0,0, 8,4'b0011,0,6'b000001));
    tbl.push_back(mk(1,1,0,1,1,0, 1,4'b0000,0,6'b100001));
    tbl.push_back(mk(1,1,0,1,0,0,16,4'b0000,0,6'b100001));
    tbl.push_back(mk(1,1,0,1,0,1, 1,4'b0001,0,6'b000000));
    tbl.push_back(mk(1,1,0,1,0,0,24,4'b1111,1,6'b000000));
    tbl.push_back(mk(1,1,0,0,0,0, 1,4'b1111,1,6'b000000));
    tbl.push_back(mk(1,1,0,1,0,0, 1,4'b1111,1,6'b000000));
    tbl.push_back(mk(1,1,0,1,0,0, 1,4'b0000,0,6'b010000));
    tbl.push_back(mk(1,1,0,1,0,0,40,4'b0111,0,6'b010000));
    tbl.push_back(mk(1,1,0,1,0,0, 1,4'b1111,1,6'b010000));
    tbl.push_back(mk(0,1,1,1,0,0, 1,4'b1111,1,6'b010000));
    tbl.push_back(mk(0,1,1,1,0,0, 1,4'b1111,1,6'b010000));
    tbl.push_back(mk(0,1,1,1,0,1, 1,4'b0000,0,6'b001010));
    tbl.push_back(mk(1,1,0,1,0,0,13,4'b0000,0,6'b001010));
    tbl.push_back(mk(0,1,0,1,0,0, 3,4'b0000,0,6'b001010));
    tbl.push_back(mk(1,1,0,1,0,0,18,4'b0000,0,6'b001010));
    tbl.push_back(mk(1,1,0,1,0,0, 1,4'b0001,0,6'b001010));
    tbl.push_back(mk(1,1,0,1,0,0,24,4'b1111,1,6'b001010));

    repeat (3) @(negedge clk);
    chk("por_hold", 4'b0000, 1'b0, 6'b000001);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      ext_rst_n  = tbl[i].e;
      aux_rst_n  = tbl[i].a;
      dbg_rst    = tbl[i].d;
      pll_locked = tbl[i].l;
      sw_rst_req = tbl[i].s;
      cause_clr  = tbl[i].c;
      repeat (tbl[i].n) tick();
      chk($sformatf("vec%0d", i), tbl[i].on, tbl[i].dn, tbl[i].ca);
    end
    ext_rst_n  = 1'b1;
    aux_rst_n  = 1'b1;
    dbg_rst    = 1'b0;
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;
    cause_clr  = 1'b0;

    async_por();
    tick();
    chk("after_por", 4'b0000, 1'b0, 6'b000001);

    h_ext = 0; h_aux = 0; h_dbg = 0; h_lock = 0;
    for (int it = 0; it < 4000; it++) begin
      if (h_ext  == 0 && $urandom_range(0, 599) == 0)
        h_ext  = $urandom_range(1, 4);
      if (h_aux  == 0 && $urandom_range(0, 599) == 0)
        h_aux  = $urandom_range(1, 4);
      if (h_dbg  == 0 && $urandom_range(0, 599) == 0)
        h_dbg  = $urandom_range(1, 4);
      if (h_lock == 0 && $urandom_range(0, 599) == 0)
        h_lock = $urandom_range(1, 4);
      ext_rst_n  = (h_ext  == 0);
      aux_rst_n  = (h_aux  == 0);
      dbg_rst    = (h_dbg  != 0);
      pll_locked = (h_lock == 0);
      if (h_ext  > 0) h_ext--;
      if (h_aux  > 0) h_aux--;
      if (h_dbg  > 0) h_dbg--;
      if (h_lock > 0) h_lock--;
      sw_rst_req = ($urandom_range(0, 499) == 0);
      cause_clr  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 1499) == 0)
        async_por();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
